// File: rtl/dmem_responder.sv
// Data-memory responder: captures one load/store, waits WAIT_CYCLES, then acks.
// state | meaning: S_IDLE waiting for req | S_WAIT counting wait states | S_RESP one-cycle ack and access
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [63:0] addr_i,
  input  logic [1:0]  tam_i,
  input  logic [63:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [63:0] rdata_o,
  output logic        err_o
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [63:0] addr_q;
  logic        we_q;
  logic [1:0]  tam_q;
  logic [63:0] wdata_q;
  logic        busy_q;
  logic        ack_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem_q [DEPTH];

  logic [63:0] src_addr;
  logic [1:0]  src_tam;
  logic        src_we;
  logic [2:0]  src_lane;
  logic        src_misal;
  logic        src_oor;
  logic        src_err;
  logic [63:0] src_word;
  logic [63:0] size_mask;
  logic [63:0] src_rdata;

  // In IDLE the live inputs are the request (WAIT_CYCLES=0 responds straight from capture)
  always_comb begin
    src_addr  = (state_q == S_IDLE) ? addr_i : addr_q;
    src_tam   = (state_q == S_IDLE) ? tam_i : tam_q;
    src_we    = (state_q == S_IDLE) ? we_i : we_q;
    src_lane  = src_addr[2:0];
    src_misal = 1'b0;
    size_mask = 64'hFF;
    unique case (src_tam)
      2'b00: begin
        src_misal = 1'b0;
        size_mask = 64'h0000_0000_0000_00FF;
      end
      2'b01: begin
        src_misal = src_lane[0];
        size_mask = 64'h0000_0000_0000_FFFF;
      end
      2'b10: begin
        src_misal = |src_lane[1:0];
        size_mask = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        src_misal = |src_lane;
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
    src_oor   = src_addr[63:3] >= 61'(DEPTH);
    src_err   = src_misal | src_oor;
    src_word  = mem_q[src_addr[IDXW+2:3]];
    src_rdata = (src_err || src_we) ? '0 : ((src_word >> {src_lane, 3'b000}) & size_mask);
  end

  logic [2:0]  wr_lane;
  logic [7:0]  size_be;
  logic [7:0]  wr_be;
  logic [63:0] wr_data;
  logic        wr_en;

  always_comb begin
    wr_lane = addr_q[2:0];
    unique case (tam_q)
      2'b00:   size_be = 8'h01;
      2'b01:   size_be = 8'h03;
      2'b10:   size_be = 8'h0F;
      default: size_be = 8'hFF;
    endcase
    wr_be   = size_be << wr_lane;
    wr_data = wdata_q << {wr_lane, 3'b000};
    wr_en   = rst_ni && (state_q == S_RESP) && we_q && !err_q;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        if (wr_be[k]) mem_q[addr_q[IDXW+2:3]][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      tam_q   <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            we_q    <= we_i;
            tam_q   <= tam_i;
            wdata_q <= wdata_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
              ack_q   <= 1'b1;
              rdata_q <= src_rdata;
              err_q   <= src_err;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_q <= S_RESP;
            ack_q   <= 1'b1;
            rdata_q <= src_rdata;
            err_q   <= src_err;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table through a scoreboard, plus hold-req,
// mid-transaction reset and zero-wait-state sequences.
module tb_dmem_responder;

  localparam int WAIT_A = 2;

  logic clk;
  logic rst_n;

  logic        req_a, we_a;
  logic [63:0] addr_a, wdata_a;
  logic [1:0]  tam_a;
  logic        busy_a, ack_a, err_a;
  logic [63:0] rdata_a;

  logic        req_b, we_b;
  logic [63:0] addr_b, wdata_b;
  logic [1:0]  tam_b;
  logic        busy_b, ack_b, err_b;
  logic [63:0] rdata_b;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .tam_i(tam_a), .wdata_i(wdata_a), .busy_o(busy_a), .ack_o(ack_a),
    .rdata_o(rdata_a), .err_o(err_a)
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .tam_i(tam_b), .wdata_i(wdata_b), .busy_o(busy_b), .ack_o(ack_b),
    .rdata_o(rdata_b), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit mon_en = 1'b0;
  logic [64:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard side: every ack on dut_a pops one expected {err, rdata}
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack_a) begin
        logic        has;
        logic [64:0] e;
        has = (exp_q.size() != 0);
        chk("ack_expected", 64'(has), 64'd1);
        if (has) begin
          e = exp_q.pop_front();
          chk("rdata", rdata_a, e[63:0]);
          chk("err", 64'(err_a), 64'(e[64]));
        end
      end else begin
        chk("idle_outputs_zero", rdata_a | 64'(err_a), 64'd0);
      end
    end
  end

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [1:0]  tam;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  // Called at a negedge with dut_a idle; returns at a negedge with dut_a idle
  task automatic do_txn(input logic we, input logic [63:0] addr, input logic [1:0] tam,
                        input logic [63:0] wdata, input logic [63:0] exp_rd, input logic exp_err);
    bit got;
    req_a = 1'b1; we_a = we; addr_a = addr; tam_a = tam; wdata_a = wdata;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0; addr_a = 64'hFFFF_0000_0000_0003; wdata_a = '1;
    got = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(negedge clk);
      chk("busy_during_access", 64'(busy_a), 64'd1);
      if (ack_a) begin
        chk("ack_latency", 64'(n), 64'(WAIT_A + 1));
        got = 1'b1;
        break;
      end
    end
    chk("ack_seen", 64'(got), 64'd1);
    @(negedge clk);
    chk("busy_after_ack", 64'(busy_a), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 64'h10,  2'b11, 64'h1122334455667788, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 64'h10,  2'b11, 64'h0, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b1, 64'h13,  2'b00, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 64'h10,  2'b11, 64'h0, 64'h11223344AB667788, 1'b0};
    vecs[4]  = '{1'b0, 64'h16,  2'b01, 64'h0, 64'h0000000000001122, 1'b0};
    vecs[5]  = '{1'b1, 64'h12,  2'b10, 64'hDEADBEEF, 64'h0, 1'b1};
    vecs[6]  = '{1'b0, 64'h10,  2'b11, 64'h0, 64'h11223344AB667788, 1'b0};
    vecs[7]  = '{1'b0, 64'h800, 2'b11, 64'h0, 64'h0, 1'b1};
    vecs[8]  = '{1'b0, 64'h17,  2'b00, 64'h0, 64'h11, 1'b0};
    vecs[9]  = '{1'b0, 64'h14,  2'b10, 64'h0, 64'h11223344, 1'b0};
    vecs[10] = '{1'b1, 64'h18,  2'b11, 64'h0, 64'h0, 1'b0};
    vecs[11] = '{1'b1, 64'h1E,  2'b01, 64'h1234CAFE, 64'h0, 1'b0};
    vecs[12] = '{1'b0, 64'h18,  2'b11, 64'h0, 64'hCAFE000000000000, 1'b0};
    vecs[13] = '{1'b0, 64'h11,  2'b01, 64'h0, 64'h0, 1'b1};
    vecs[14] = '{1'b1, 64'h7F8, 2'b11, 64'h0123456789ABCDEF, 64'h0, 1'b0};
    vecs[15] = '{1'b0, 64'h7F8, 2'b11, 64'h0, 64'h0123456789ABCDEF, 1'b0};
    vecs[16] = '{1'b1, 64'h20,  2'b11, 64'h0102030405060708, 64'h0, 1'b0};
    vecs[17] = '{1'b0, 64'h1C,  2'b10, 64'h0, 64'hCAFE0000, 1'b0};

    rst_n = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; tam_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; tam_b = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_ack", 64'(ack_a), 64'd0);
    chk("reset_rdata", rdata_a, 64'd0);
    chk("reset_err", 64'(err_a), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++)
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].tam, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);

    // req held high with addr changing every cycle: only IDLE-edge addresses count
    for (int k = 0; k < 12; k++) begin
      req_a = 1'b1; we_a = 1'b0; tam_a = 2'b11;
      unique case (k)
        0:       addr_a = 64'h10;
        4:       addr_a = 64'h18;
        8:       addr_a = 64'h800;
        default: addr_a = (k % 2 == 1) ? 64'h7F8 : 64'h13;
      endcase
      if (k == 0) exp_q.push_back({1'b0, 64'h11223344AB667788});
      if (k == 4) exp_q.push_back({1'b0, 64'hCAFE000000000000});
      if (k == 8) exp_q.push_back({1'b1, 64'h0});
      @(posedge clk);
      @(negedge clk);
      chk("hold_req_ack_slot", 64'(ack_a), 64'(k % 4 == 2));
    end
    req_a = 1'b0;
    @(negedge clk);

    // Reset one cycle after capturing a store: aborted, no write
    req_a = 1'b1; we_a = 1'b1; addr_a = 64'h20; tam_a = 2'b00; wdata_a = 64'hFF;
    @(posedge clk);
    @(negedge clk);
    req_a = 1'b0;
    chk("abort_busy_before_reset", 64'(busy_a), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_ack", 64'(ack_a), 64'd0);
    chk("abort_rdata", rdata_a, 64'd0);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("abort_no_ack", 64'(ack_a), 64'd0);
    end
    do_txn(1'b0, 64'h20, 2'b11, 64'h0, 64'h0102030405060708, 1'b0);
    do_txn(1'b0, 64'h20, 2'b00, 64'h0, 64'h08, 1'b0);

    // Zero wait states: ack in the cycle right after capture
    req_b = 1'b1; we_b = 1'b1; addr_b = 64'h10; tam_b = 2'b11; wdata_b = 64'hA5A5_5A5A_0F0F_F0F0;
    @(posedge clk);
    @(negedge clk);
    req_b = 1'b0;
    chk("w0_store_ack", 64'(ack_b), 64'd1);
    chk("w0_store_busy", 64'(busy_b), 64'd1);
    chk("w0_store_err", 64'(err_b), 64'd0);
    @(negedge clk);
    chk("w0_idle_ack", 64'(ack_b), 64'd0);
    chk("w0_idle_busy", 64'(busy_b), 64'd0);
    req_b = 1'b1; we_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("w0_load_ack", 64'(ack_b), 64'd1);
    chk("w0_load_rdata", rdata_b, 64'hA5A5_5A5A_0F0F_F0F0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("w0_b2b_ack", 64'(ack_b), 64'(k % 2 == 1));
      chk("w0_b2b_rdata", rdata_b, (k % 2 == 1) ? 64'hA5A5_5A5A_0F0F_F0F0 : 64'h0);
    end
    req_b = 1'b0;

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
